// File: rtl/mem_handshake_ram.sv
// Byte-addressed, big-endian main memory that answers the control unit's
// MFA/MFC handshake. A request is latched in IDLE, optionally delayed by
// WAIT_STATES cycles, performed on the WAIT-to-DONE edge, and then held
// complete (MFC=1) until the CU drops MFA. Misaligned halfword and word
// accesses are flagged on ALIGN_ERR and are not performed.
module mem_handshake_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        MFC,
  output logic        ALIGN_ERR,
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Storage is left uninitialised and unreset so a preloaded image survives.
  logic [7:0] ram [DEPTH];

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          rw_q;
  logic          sgn_q;
  logic [31:0]   din_q;

  logic [AW-1:0] addr_p1, addr_p2, addr_p3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rdata;
  logic          misaligned;
  logic          access_now;
  logic          do_write;

  // Address bits above the array size simply alias; they carry no meaning here.
  logic          addr_hi_unused;
  assign addr_hi_unused = ^ADDR[31:AW];

  assign addr_p1 = addr_q + AW'(1);
  assign addr_p2 = addr_q + AW'(2);
  assign addr_p3 = addr_q + AW'(3);

  assign b0 = ram[addr_q];
  assign b1 = ram[addr_p1];
  assign b2 = ram[addr_p2];
  assign b3 = ram[addr_p3];

  // Reserved size 2'b11 behaves as a word, so SIZE[1] alone selects word rules.
  assign misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));

  assign access_now = (state == S_WAIT) && (cnt == 4'd0);
  assign do_write   = access_now && !rw_q && !misaligned;
  assign BUSY       = (state != S_IDLE);

  // Assemble big-endian load data, right-justified and extended per SIGNED.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    rdata = 32'h0;
    case (size_q)
      SZ_BYTE: rdata = {{24{sgn_q & b0[7]}}, b0};
      SZ_HALF: rdata = {{16{sgn_q & b0[7]}}, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  // Handshake FSM: accept in IDLE, count wait states, complete, await MFA low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      rw_q      <= 1'b0;
      sgn_q     <= 1'b0;
      din_q     <= 32'h0;
      DOUT      <= 32'h0;
      MFC       <= 1'b0;
      ALIGN_ERR <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        S_IDLE: begin
          if (MFA) begin
            addr_q <= ADDR[AW-1:0];
            size_q <= SIZE;
            rw_q   <= RW;
            sgn_q  <= SIGNED;
            din_q  <= DIN;
            cnt    <= 4'(WAIT_STATES);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            MFC       <= 1'b1;
            ALIGN_ERR <= misaligned;
            if (rw_q && !misaligned) DOUT <= rdata;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!MFA) begin
            MFC       <= 1'b0;
            ALIGN_ERR <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Store path: commits only on the completing edge of an aligned write.
  // NOTE: the array has no reset branch, so it stays a plain RAM and keeps its
  // contents across Reset; a reset during WAIT forces IDLE and so blocks the write.
  always @(posedge Clk) begin
    if (do_write) begin
      case (size_q)
        SZ_BYTE: ram[addr_q] <= din_q[7:0];
        SZ_HALF: begin
          ram[addr_q]  <= din_q[15:8];
          ram[addr_p1] <= din_q[7:0];
        end
        default: begin
          ram[addr_q]  <= din_q[31:24];
          ram[addr_p1] <= din_q[23:16];
          ram[addr_p2] <= din_q[15:8];
          ram[addr_p3] <= din_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Bench for mem_handshake_ram: a table of load/store transactions replayed
// through the MFA/MFC handshake with a scoreboard of expected completions,
// plus hand-written sequences for reset-mid-WAIT and the reset state.
module tb_mem_handshake_ram;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MFA;
  logic        RW;
  logic [1:0]  SIZE;
  logic        sgn;
  logic [31:0] ADDR;
  logic [31:0] DIN;
  logic [31:0] DOUT,  dout1;
  logic        MFC,   mfc1;
  logic        ALIGN_ERR, aerr1;
  logic        BUSY,  busy1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_handshake_ram #(.DEPTH(256), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW), .SIZE(SIZE), .SIGNED(sgn),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .MFC(MFC), .ALIGN_ERR(ALIGN_ERR),
    .BUSY(BUSY)
  );

  // Zero-wait-state copy sharing the same request lines, used for latency.
  mem_handshake_ram #(.DEPTH(256), .WAIT_STATES(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW), .SIZE(SIZE), .SIGNED(sgn),
    .ADDR(ADDR), .DIN(DIN), .DOUT(dout1), .MFC(mfc1), .ALIGN_ERR(aerr1),
    .BUSY(busy1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete handshake: raise MFA, scramble inputs after acceptance,
  // wait (bounded) for MFC, compare against the scoreboard, optionally hold
  // MFA in DONE, then release and confirm the return to IDLE.
  task automatic run(input logic rw, input logic [1:0] size, input logic s,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_dout, input logic exp_err,
                     input int hold, input string tag);
    int   cycles;
    int   lat1;
    int   stay;
    exp_t e;
    @(negedge Clk);
    RW = rw; SIZE = size; sgn = s; ADDR = addr; DIN = din; MFA = 1'b1;
    sb.push_back('{dout: exp_dout, err: exp_err});
    cycles = 0;
    lat1   = 0;
    do begin
      @(posedge Clk); #1;
      cycles++;
      if (cycles == 1) begin
        ADDR = $urandom;
        DIN  = $urandom;
      end
      if (mfc1 && lat1 == 0) lat1 = cycles;
    end while (!MFC && cycles < 40);
    check({tag, " latency"}, 32'(cycles), 32'(WS + 2));
    check({tag, " latency ws0"}, 32'(lat1), 32'd2);
    e = sb.pop_front();
    check({tag, " dout"}, DOUT, e.dout);
    check({tag, " align_err"}, {31'd0, ALIGN_ERR}, {31'd0, e.err});
    if (hold > 0) begin
      stay = 0;
      repeat (hold) begin
        @(posedge Clk); #1;
        if (MFC && BUSY) stay++;
      end
      check({tag, " hold done"}, 32'(stay), 32'(hold));
      check({tag, " hold dout"}, DOUT, e.dout);
    end
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk); #1;
    check({tag, " release"}, {29'd0, MFC, BUSY, ALIGN_ERR}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; MFA = 1'b0; RW = 1'b1; SIZE = 2'b00; sgn = 1'b0;
    ADDR = 32'h0; DIN = 32'h0;

    for (int i = 0; i < 256; i++) begin
      dut.ram[i]  = 8'h00;
      dut1.ram[i] = 8'h00;
    end
    dut.ram[0]  = 8'h9C; dut.ram[1]  = 8'h04; dut.ram[2]  = 8'h40; dut.ram[3]  = 8'h12;
    dut1.ram[0] = 8'h9C; dut1.ram[1] = 8'h04; dut1.ram[2] = 8'h40; dut1.ram[3] = 8'h12;
    dut.ram[16] = 8'h11; dut.ram[17] = 8'h22; dut.ram[18] = 8'h33; dut.ram[19] = 8'h44;

    //            rw    size   sgn   addr          din           exp_dout      err   hold
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000000, 32'h0,        32'h9C044012, 1'b0, 10};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h00000008, 32'hA2044012, 32'h9C044012, 1'b0, 0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h00000009, 32'h0,        32'h00000004, 1'b0, 0};
    vecs[3]  = '{1'b1, 2'b01, 1'b1, 32'h00000008, 32'h0,        32'hFFFFA204, 1'b0, 0};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'hFFFFA204, 1'b1, 0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h00000003, 32'h0,        32'hFFFFA204, 1'b1, 0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h00000003, 32'h00001234, 32'hFFFFA204, 1'b1, 0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h00000003, 32'h0,        32'h00000012, 1'b0, 0};
    vecs[8]  = '{1'b1, 2'b00, 1'b1, 32'h00000000, 32'h0,        32'hFFFFFF9C, 1'b0, 0};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h00000002, 32'h0,        32'h00004012, 1'b0, 0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h00000104, 32'h0000005A, 32'h00004012, 1'b0, 0};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h00000004, 32'h0,        32'h0000005A, 1'b0, 0};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h00000208, 32'h0,        32'hA2044012, 1'b0, 0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000000C, 32'hCAFEF00D, 32'hA2044012, 1'b0, 0};
    vecs[14] = '{1'b1, 2'b01, 1'b1, 32'h0000000E, 32'h0,        32'hFFFFF00D, 1'b0, 0};
    vecs[15] = '{1'b1, 2'b00, 1'b1, 32'h0000000D, 32'h0,        32'hFFFFFFFE, 1'b0, 0};
    vecs[16] = '{1'b1, 2'b10, 1'b1, 32'h0000000C, 32'h0,        32'hCAFEF00D, 1'b0, 0};

    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("reset state", {DOUT[30:0], MFC, ALIGN_ERR, BUSY}, 34'h0);

    for (int i = 0; i < 17; i++) begin
      run(vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].din,
          vecs[i].exp_dout, vecs[i].exp_err, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Misaligned store at 3 must have left ram[3] untouched.
    check("misaligned store ram", {24'd0, dut.ram[3]}, 32'h00000012);

    // Reset asserted in the middle of WAIT on a word store.
    @(negedge Clk);
    RW = 1'b0; SIZE = 2'b10; sgn = 1'b0; ADDR = 32'h10; DIN = 32'hDEADBEEF; MFA = 1'b1;
    @(posedge Clk); #1;
    check("mid-wait busy", {31'd0, BUSY}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("reset immediate", {DOUT, MFC, BUSY}, 34'h0);
    MFA = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check("reset no commit",
          {dut.ram[16], dut.ram[17], dut.ram[18], dut.ram[19]}, 32'h11223344);
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 0, "post-reset read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_handshake_ram.md
Name: mem_handshake_ram

Overview:
- Byte-addressed, big-endian main memory that answers the control unit's MFA/MFC handshake.
- Sits directly downstream of the datapath's MAR/MDR. It consumes the address, store data, access size and direction that the CU drives. It produces load data for MDR and the MFC completion strobe the CU waits on.
- Adds programmable wait states and flags misaligned accesses for the SPARC mem_address_not_aligned trap.

Parameters:
DEPTH, 256, memory size in bytes (power of two); the address is taken modulo DEPTH.
WAIT_STATES, 2, extra cycles between MFA acceptance and MFC assertion (0..15).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
MFA  input  1  memory function activate; request held high until MFC is seen
RW  input  1  1 = read (load), 0 = write (store)
SIZE  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
SIGNED  input  1  loads only: 1 = sign-extend byte/halfword, 0 = zero-extend
ADDR  input  32  byte address, driven from MAR
DIN  input  32  store data from MDR, right-justified
DOUT  output  32  load data to MDR, right-justified and extended
MFC  output  1  memory function complete
ALIGN_ERR  output  1  valid while MFC=1; access was misaligned and was not performed
BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - MFC=0, ALIGN_ERR=0, BUSY=0, DOUT=32'h0, wait counter=0.
  - Memory array contents are NOT cleared, so testbench preload survives reset.
- State IDLE:
  - On a rising edge with MFA=1, latch ADDR mod DEPTH, SIZE, RW, SIGNED and DIN.
  - Load counter with WAIT_STATES and go to WAIT.
- State WAIT:
  - Each edge: if counter!=0, decrement it. Otherwise perform the access and go to DONE.
  - Inputs are not resampled in WAIT; changes to ADDR/DIN after acceptance are ignored.
- Access, evaluated on the WAIT-to-DONE edge:
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: no memory write, DOUT unchanged, ALIGN_ERR=1.
  - Aligned write: byte writes DIN[7:0] to mem[a]. Halfword writes DIN[15:8] to mem[a] and DIN[7:0] to mem[a+1]. Word writes DIN[31:24] to mem[a] through DIN[7:0] to mem[a+3] (big-endian). DOUT unchanged. ALIGN_ERR=0.
  - Aligned read: DOUT = the bytes assembled big-endian, right-justified, extended per SIGNED. Word reads ignore SIGNED. ALIGN_ERR=0.
- State DONE:
  - MFC=1 and DOUT is stable.
  - Remain in DONE while MFA=1.
  - On the first edge with MFA=0: MFC=0, ALIGN_ERR=0, go to IDLE.
  - A new request is accepted no earlier than the next edge. One request gets exactly one MFC pulse; back-to-back requests need MFA low for at least 1 cycle.
- Latency: MFA sampled high at edge t gives MFC=1 after edge t+WAIT_STATES+1. With WAIT_STATES=0, MFC rises after the following edge.
- Address wrap:
  - Addresses at or above DEPTH alias modulo DEPTH. No error is raised.
  - For aligned accesses, multi-byte offsets never cross DEPTH because DEPTH is a power of two ≥4.
- MFA dropping during WAIT: the access still completes and MFC pulses for exactly 1 cycle, then the block returns to IDLE. The CU must not rely on this.
- Reset asserted mid-WAIT: an incomplete write is not committed. Memory keeps its prior contents and the block returns to IDLE.
- Direct array access: the array is a plain reg [7:0] array named ram, so benches can preload it hierarchically.

Test Plan:
1. Preload ram[0..3]=9C,04,40,12; WAIT_STATES=2; read word at 0 -> MFC rises 3 edges after MFA sampled; DOUT=32'h9C044012; ALIGN_ERR=0.
2. Write word 32'hA2044012 at addr 8; drop MFA; then read byte at 9 with SIGNED=0 -> DOUT=32'h00000004. Read halfword at 8 with SIGNED=1 -> DOUT=32'hFFFFA204.
3. Read word at addr 6 -> MFC=1 with ALIGN_ERR=1; DOUT holds its previous value; ram unchanged. Halfword at addr 3 -> ALIGN_ERR=1.
4. Hold MFA high 10 cycles after MFC -> MFC stays 1 and no second access occurs. Drop MFA -> MFC=0 next edge, BUSY=0. Re-raise MFA -> new transaction starts.
5. Assert Reset=0 in the middle of WAIT on a word write of 32'hDEADBEEF at addr 16 -> MFC/BUSY/DOUT go to 0 immediately; ram[16..19] keeps prior contents; a later read returns the old data.
6. DEPTH=256: write byte 8'h5A at addr 32'h00000104 -> a read of addr 4 returns 32'h0000005A. WAIT_STATES=0 -> MFC rises 1 edge after MFA sampled.
